tmds_video_sequencer: RTL and testbench
=======================================

Name: tmds_video_sequencer

Overview:
- Timing controller and scheduler that drives the three TMDS channel encoders (blue = ch0, green = ch1, red = ch2).
- Generates raster counters, hsync/vsync, the video-data-enable and the per-channel 2-bit control data.
- Pulls pixels from an upstream pixel source over a valid/ready handshake.
- Optionally inserts the HDMI video preamble (CTL pattern) ahead of each active line; sits between the frame-buffer reader and the encoders.

Parameters:
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch clocks
- H_SYNC, 96, hsync width clocks
- H_BP, 48, horizontal back porch clocks; must be >= PREAMBLE_LEN when PREAMBLE_EN=1
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch lines
- V_SYNC, 2, vsync width lines
- V_BP, 33, vertical back porch lines
- HSYNC_POL, 0, hsync asserted level (0 = active-low)
- VSYNC_POL, 0, vsync asserted level
- PREAMBLE_EN, 1, 1 = emit HDMI video preamble on ch1/ch2 control data
- PREAMBLE_LEN, 8, preamble length in clocks

Ports:
- clk, in, 1, pixel clock
- rst_n, in, 1, synchronous reset, active-low
- en, in, 1, run request
- pix_data, in, 24, {R[23:16], G[15:8], B[7:0]}
- pix_valid, in, 1, pix_data valid
- pix_ready, out, 1, sequencer accepts pixel this cycle
- vde, out, 1, encoder VDE (shared by all channels)
- cd0, out, 2, ch0 control data {vsync, hsync}
- cd1, out, 2, ch1 control data {CTL1, CTL0}
- cd2, out, 2, ch2 control data {CTL3, CTL2}
- vd_b, out, 8, ch0 video data
- vd_g, out, 8, ch1 video data
- vd_r, out, 8, ch2 video data
- frame_start, out, 1, one-clock pulse on first output cycle of each frame
- underflow, out, 1, sticky: active pixel slot had no valid pixel
- busy, out, 1, high in RUN or DRAIN

Behaviour:
- Derived totals: H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP and V_TOTAL = V_SYNC+V_BP+V_ACTIVE+V_FP.
- Counters: hcnt wraps 0..H_TOTAL-1. vcnt increments when hcnt wraps and itself wraps 0..V_TOTAL-1.
- Region order is the same in both dimensions: SYNC, BP, ACTIVE, FP. Thus h-active = hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACTIVE-1], and v-active is the analogous range on vcnt.
- FSM states:
  - IDLE: counters held at 0.
  - RUN: counters advance every clock.
  - DRAIN: counters advance; en has dropped.
- FSM transitions:
  - IDLE to RUN when en=1; counting starts at hcnt=0, vcnt=0 on the next clock.
  - RUN to DRAIN when en=0.
  - DRAIN to RUN if en returns to 1 before the frame ends.
  - DRAIN to IDLE after the cycle with hcnt=H_TOTAL-1 and vcnt=V_TOTAL-1; a frame is never truncated.
- pix_ready: combinational; equals (state != IDLE) AND h-active AND v-active. Pixel transfer = pix_valid & pix_ready. pix_valid outside active slots is ignored.
- Output registers, all 1-clock latency from counter position:
  - vde <= pix_ready.
  - cd0 <= {vsync, hsync}, where hsync = HSYNC_POL during the h-SYNC region and ~HSYNC_POL otherwise (vsync likewise).
  - vd_r/g/b <= pix_data when transfer occurs; 0 otherwise.
- Underflow: an active slot with pix_valid=0 still advances the raster, outputs vd = 0 with vde = 1, and sets underflow. Underflow clears only in IDLE or on reset.
- Preamble: cd1 <= 2'b01 and cd2 <= 2'b00 when PREAMBLE_EN=1, v-active, and hcnt in [H_SYNC+H_BP-PREAMBLE_LEN, H_SYNC+H_BP-1]. At all other times cd1 = cd2 = 2'b00.
- frame_start <= (state != IDLE AND hcnt=0 AND vcnt=0).
- In IDLE: vde=0, vd=0, cd0={~VSYNC_POL, ~HSYNC_POL}, cd1=cd2=0, pix_ready=0, busy=0.
- Reset (rst_n=0 at clk edge, any time including mid-line):
  - state=IDLE, counters=0, underflow=0, frame_start=0.
  - vde=0, vd_*=0, cd0={~VSYNC_POL, ~HSYNC_POL}, cd1=cd2=0.
  - In-flight pixel discarded, no partial-line continuation.
- Widths: counters are $clog2(H_TOTAL) and $clog2(V_TOTAL) bits; compares use full width, no wrap aliasing.

Test Plan:
- Bench parameters: H_ACTIVE=4, H_FP=2, H_SYNC=2, H_BP=3, V_ACTIVE=2, V_FP=1, V_SYNC=1, V_BP=1, PREAMBLE_LEN=2, pols=0. This gives H_TOTAL=11 and a 55-clock frame.
- Reset with en=1 and rst_n=0 for 3 clocks, then released -> all outputs at reset values during reset. frame_start pulses 2 clocks after release, then every 55 clocks.
- Continuous pix_valid=1 with incrementing data -> pix_ready high for hcnt 5..8 on vcnt 2,3. vde high exactly 4 clocks per active line, one clock later. vd_* carries the data in order. Period is 11 clocks. underflow stays 0.
- pix_valid dropped for the 2nd pixel of line vcnt=2 -> vd_r/g/b=0 with vde=1 for that slot; underflow=1 and stays 1. Later pixels are not shifted.
- Preamble check -> cd1=01 exactly on the output cycles for hcnt 3,4 of vcnt 2,3; cd1=00 on vcnt 0,1,4. cd0[0]=0 for hcnt 0,1 only. cd0[1]=0 for all of vcnt 0.
- en dropped at hcnt=6, vcnt=2 -> busy stays 1. Raster completes to hcnt=10, vcnt=4, then IDLE, busy=0, no further frame_start. Re-asserting en before frame end keeps RUN without a gap.
- rst_n pulsed at hcnt=7, vcnt=3 -> next clock vde=0 and underflow=0. Restart from hcnt=0, vcnt=0 with frame_start 2 clocks after release.

Source files
------------

// File: rtl/tmds_video_sequencer_if.sv
// Pixel stream handshake between the frame-buffer reader (master) and the
// TMDS video sequencer (slave).
interface tmds_video_sequencer_if;
  logic [23:0] pix_data;
  logic        pix_valid;
  logic        pix_ready;

  modport master (output pix_data, output pix_valid, input pix_ready);
  modport slave  (input pix_data, input pix_valid, output pix_ready);
endinterface

// File: rtl/tmds_video_sequencer.sv
// Raster timing and scheduling for three TMDS channel encoders: counters,
// syncs, VDE, control data with optional HDMI video preamble, pixel pull.
module tmds_video_sequencer #(
  parameter int H_ACTIVE     = 640,
  parameter int H_FP         = 16,
  parameter int H_SYNC       = 96,
  parameter int H_BP         = 48,
  parameter int V_ACTIVE     = 480,
  parameter int V_FP         = 10,
  parameter int V_SYNC       = 2,
  parameter int V_BP         = 33,
  parameter bit HSYNC_POL    = 1'b0,
  parameter bit VSYNC_POL    = 1'b0,
  parameter int PREAMBLE_EN  = 1,
  parameter int PREAMBLE_LEN = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  tmds_video_sequencer_if.slave        pix,
  output logic                         vde,
  output logic [1:0]                   cd0,
  output logic [1:0]                   cd1,
  output logic [1:0]                   cd2,
  output logic [7:0]                   vd_b,
  output logic [7:0]                   vd_g,
  output logic [7:0]                   vd_r,
  output logic                         frame_start,
  output logic                         underflow,
  output logic                         busy
);

  localparam int H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
  localparam int V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  // Preamble is only emitted when it fits entirely inside the back porch.
  localparam bit PRE_ON   = (PREAMBLE_EN != 0) && (PREAMBLE_LEN > 0) && (H_BP >= PREAMBLE_LEN);
  localparam int PRE_LEN  = PRE_ON ? PREAMBLE_LEN : 0;

  // Compare constants carry one extra bit so H_TOTAL == 2**HW cannot alias.
  localparam logic [HW:0] H_SYNC_END = (HW+1)'(H_SYNC);
  localparam logic [HW:0] H_ACT_LO   = (HW+1)'(H_SYNC + H_BP);
  localparam logic [HW:0] H_ACT_HI   = (HW+1)'(H_SYNC + H_BP + H_ACTIVE);
  localparam logic [HW:0] H_PRE_LO   = (HW+1)'(H_SYNC + H_BP - PRE_LEN);
  localparam logic [HW:0] H_LAST     = (HW+1)'(H_TOTAL - 1);
  localparam logic [VW:0] V_SYNC_END = (VW+1)'(V_SYNC);
  localparam logic [VW:0] V_ACT_LO   = (VW+1)'(V_SYNC + V_BP);
  localparam logic [VW:0] V_ACT_HI   = (VW+1)'(V_SYNC + V_BP + V_ACTIVE);
  localparam logic [VW:0] V_LAST     = (VW+1)'(V_TOTAL - 1);
  localparam logic [HW-1:0] H_ONE    = HW'(1);
  localparam logic [VW-1:0] V_ONE    = VW'(1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_nxt_s;
  logic [HW-1:0]   hcnt_r;
  logic [HW-1:0]   hcnt_nxt_s;
  logic [VW-1:0]   vcnt_r;
  logic [VW-1:0]   vcnt_nxt_s;
  logic [HW:0]     hpos_s;
  logic [VW:0]     vpos_s;
  logic            active_st_s;
  logic            h_sync_s;
  logic            v_sync_s;
  logic            h_act_s;
  logic            v_act_s;
  logic            h_pre_s;
  logic            frame_end_s;
  logic            pix_ready_s;
  logic            xfer_s;
  logic            hsync_s;
  logic            vsync_s;
  logic            preamble_s;

  // Raster region decode from the current counter position
  always_comb begin
    hpos_s      = {1'b0, hcnt_r};
    vpos_s      = {1'b0, vcnt_r};
    active_st_s = (state_r != ST_IDLE);
    h_sync_s    = (hpos_s < H_SYNC_END);
    v_sync_s    = (vpos_s < V_SYNC_END);
    h_act_s     = (hpos_s >= H_ACT_LO) && (hpos_s < H_ACT_HI);
    v_act_s     = (vpos_s >= V_ACT_LO) && (vpos_s < V_ACT_HI);
    h_pre_s     = PRE_ON && (hpos_s >= H_PRE_LO) && (hpos_s < H_ACT_LO);
    frame_end_s = (hpos_s == H_LAST) && (vpos_s == V_LAST);
    pix_ready_s = active_st_s && h_act_s && v_act_s;
    xfer_s      = pix_ready_s && pix.pix_valid;
    hsync_s     = (active_st_s && h_sync_s) ? HSYNC_POL : ~HSYNC_POL;
    vsync_s     = (active_st_s && v_sync_s) ? VSYNC_POL : ~VSYNC_POL;
    preamble_s  = active_st_s && v_act_s && h_pre_s;
  end

  assign pix.pix_ready = pix_ready_s;
  assign busy          = active_st_s;

  // Run/drain control; draining always finishes the current frame
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (en) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN, ST_DRAIN: begin
        if (en) begin
          state_nxt_s = ST_RUN;
        end else if (frame_end_s) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Raster counter advance, held at the origin while idle
  always_comb begin
    hcnt_nxt_s = hcnt_r;
    vcnt_nxt_s = vcnt_r;
    if (!active_st_s) begin
      hcnt_nxt_s = '0;
      vcnt_nxt_s = '0;
    end else if (hpos_s == H_LAST) begin
      hcnt_nxt_s = '0;
      if (vpos_s == V_LAST) begin
        vcnt_nxt_s = '0;
      end else begin
        vcnt_nxt_s = vcnt_r + V_ONE;
      end
    end else begin
      hcnt_nxt_s = hcnt_r + H_ONE;
      vcnt_nxt_s = vcnt_r;
    end
  end

  // State and raster counter registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      hcnt_r  <= '0;
      vcnt_r  <= '0;
    end else begin
      state_r <= state_nxt_s;
      hcnt_r  <= hcnt_nxt_s;
      vcnt_r  <= vcnt_nxt_s;
    end
  end

  // Encoder-facing outputs, one clock behind the raster position
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vde         <= 1'b0;
      cd0         <= {~VSYNC_POL, ~HSYNC_POL};
      cd1         <= 2'b00;
      cd2         <= 2'b00;
      vd_r        <= 8'h00;
      vd_g        <= 8'h00;
      vd_b        <= 8'h00;
      frame_start <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      vde         <= pix_ready_s;
      cd0         <= {vsync_s, hsync_s};
      cd1         <= preamble_s ? 2'b01 : 2'b00;
      cd2         <= 2'b00;
      frame_start <= active_st_s && (hcnt_r == '0) && (vcnt_r == '0);
      if (xfer_s) begin
        vd_r <= pix.pix_data[23:16];
        vd_g <= pix.pix_data[15:8];
        vd_b <= pix.pix_data[7:0];
      end else begin
        vd_r <= 8'h00;
        vd_g <= 8'h00;
        vd_b <= 8'h00;
      end
      // Starved slots still advance the raster; the flag is sticky until idle.
      if (!active_st_s) begin
        underflow <= 1'b0;
      end else if (pix_ready_s && !pix.pix_valid) begin
        underflow <= 1'b1;
      end else begin
        underflow <= underflow;
      end
    end
  end

endmodule

// File: tb/tb_tmds_video_sequencer.sv
// Self-checking bench: small raster (11 x 5), reference model feeding a
// scoreboard queue, a reset/start vector table and hand-checked corner cases.
module tb_tmds_video_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        vde;
  logic [1:0]  cd0;
  logic [1:0]  cd1;
  logic [1:0]  cd2;
  logic [7:0]  vd_b;
  logic [7:0]  vd_g;
  logic [7:0]  vd_r;
  logic        frame_start;
  logic        underflow;
  logic        busy;

  tmds_video_sequencer_if pif ();

  tmds_video_sequencer #(
    .H_ACTIVE(4), .H_FP(2), .H_SYNC(2), .H_BP(3),
    .V_ACTIVE(2), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0),
    .PREAMBLE_EN(1), .PREAMBLE_LEN(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .pix(pif.slave),
    .vde(vde), .cd0(cd0), .cd1(cd1), .cd2(cd2),
    .vd_b(vd_b), .vd_g(vd_g), .vd_r(vd_r),
    .frame_start(frame_start), .underflow(underflow), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vde;
    logic [1:0]  cd0;
    logic [1:0]  cd1;
    logic [1:0]  cd2;
    logic [23:0] vd;
    logic        fs;
    logic        uf;
    logic        busy;
  } exp_t;

  typedef struct {
    logic       rst_n;
    logic       en;
    logic       vde;
    logic       fs;
    logic       busy;
    logic [1:0] cd0;
  } vec_t;

  exp_t        sb_q[$];
  int          total = 0;
  int          bad = 0;
  int          m_st = 0;
  int          m_h = 0;
  int          m_v = 0;
  logic        m_uf = 1'b0;
  logic [23:0] dctr = 24'h102030;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (model h=%0d v=%0d)", name, act, exp, m_h, m_v);
    end
  endtask

  // One clock: drive at negedge, predict from the model, compare after the edge.
  task automatic step(input logic r, input logic e, input logic pv, input logic [23:0] pd);
    exp_t x;
    exp_t y;
    bit   run;
    bit   vact;
    bit   pr;
    bit   last;
    int   nxt;
    rst_n = r;
    en = e;
    pif.pix_valid = pv;
    pif.pix_data = pd;
    #1;
    run  = (m_st != 0);
    vact = (m_v >= 2) && (m_v <= 3);
    pr   = run && vact && (m_h >= 5) && (m_h <= 8);
    check("pix_ready", 32'(pif.pix_ready), 32'(pr));
    if (!r) begin
      x.vde = 1'b0; x.cd0 = 2'b11; x.cd1 = 2'b00; x.cd2 = 2'b00;
      x.vd = 24'h0; x.fs = 1'b0; x.uf = 1'b0; x.busy = 1'b0;
      m_st = 0; m_h = 0; m_v = 0; m_uf = 1'b0;
    end else begin
      x.vde = pr;
      x.vd  = (pr && pv) ? pd : 24'h0;
      x.cd0 = run ? {(m_v < 1) ? 1'b0 : 1'b1, (m_h < 2) ? 1'b0 : 1'b1} : 2'b11;
      x.cd1 = (run && vact && (m_h == 3 || m_h == 4)) ? 2'b01 : 2'b00;
      x.cd2 = 2'b00;
      x.fs  = run && (m_h == 0) && (m_v == 0);
      if (!run) m_uf = 1'b0;
      else if (pr && !pv) m_uf = 1'b1;
      x.uf = m_uf;
      last = (m_h == 10) && (m_v == 4);
      if (m_st == 0) nxt = e ? 1 : 0;
      else nxt = e ? 1 : (last ? 0 : 2);
      if (m_st == 0) begin
        m_h = 0; m_v = 0;
      end else if (m_h == 10) begin
        m_h = 0;
        m_v = (m_v == 4) ? 0 : m_v + 1;
      end else begin
        m_h = m_h + 1;
      end
      m_st = nxt;
      x.busy = (m_st != 0);
    end
    sb_q.push_back(x);
    @(posedge clk);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      y = sb_q.pop_front();
      check("vde", 32'(vde), 32'(y.vde));
      check("cd0", 32'(cd0), 32'(y.cd0));
      check("cd1", 32'(cd1), 32'(y.cd1));
      check("cd2", 32'(cd2), 32'(y.cd2));
      check("vd_rgb", 32'({vd_r, vd_g, vd_b}), 32'(y.vd));
      check("frame_start", 32'(frame_start), 32'(y.fs));
      check("underflow", 32'(underflow), 32'(y.uf));
      check("busy", 32'(busy), 32'(y.busy));
    end
  endtask

  task automatic tick(input logic e, input logic pv);
    step(1'b1, e, pv, dctr);
    dctr = dctr + 24'h010203;
  endtask

  task automatic advance_to(input int th, input int tv);
    int n = 0;
    while (!(m_h == th && m_v == tv) && n < 200) begin
      tick(1'b1, 1'b1);
      n++;
    end
    check("advance_bound", 32'(n < 200), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    int   n;
    int   vde_n;
    int   pre_n;
    int   hs_n;
    int   vs_n;
    int   fs_n;
    int   busy_n;
    int   fs_a;
    int   fs_b;
    int   drop_left;
    bit   drop_done;
    bit   done;
    logic e;
    logic pv;

    // reset x2, release (IDLE->RUN), then h=0..4 of line 0
    tbl[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'b11};
    tbl[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b11};
    tbl[3] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'b00};
    tbl[4] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b00};
    tbl[5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01};
    tbl[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'b01};

    rst_n = 1'b0;
    en = 1'b1;
    pif.pix_valid = 1'b0;
    pif.pix_data = 24'h0;
    @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].rst_n, tbl[i].en, 1'b0, 24'h0);
      check("tbl_vde", 32'(vde), 32'(tbl[i].vde));
      check("tbl_frame_start", 32'(frame_start), 32'(tbl[i].fs));
      check("tbl_busy", 32'(busy), 32'(tbl[i].busy));
      check("tbl_cd0", 32'(cd0), 32'(tbl[i].cd0));
      check("tbl_cd1", 32'(cd1), 32'd0);
    end

    // two clean frames with continuous pixels
    advance_to(0, 0);
    vde_n = 0; pre_n = 0; hs_n = 0; vs_n = 0; fs_a = -1; fs_b = -1;
    for (int i = 0; i < 110; i++) begin
      tick(1'b1, 1'b1);
      if (vde) vde_n++;
      if (cd1 == 2'b01) pre_n++;
      if (!cd0[0]) hs_n++;
      if (!cd0[1]) vs_n++;
      if (frame_start) begin
        if (fs_a < 0) fs_a = i;
        else fs_b = i;
      end
    end
    check("vde_count", 32'(vde_n), 32'd16);
    check("preamble_count", 32'(pre_n), 32'd8);
    check("hsync_count", 32'(hs_n), 32'd20);
    check("vsync_count", 32'(vs_n), 32'd22);
    check("fs_period", 32'(fs_b - fs_a), 32'd55);
    check("clean_underflow", 32'(underflow), 32'd0);

    // starve the second pixel of line 2
    for (int i = 0; i < 55; i++) begin
      pv = !(m_v == 2 && m_h == 6);
      tick(1'b1, pv);
      if (!pv) begin
        check("starve_vde", 32'(vde), 32'd1);
        check("starve_vd", 32'({vd_r, vd_g, vd_b}), 32'd0);
        check("starve_flag", 32'(underflow), 32'd1);
      end
    end
    check("underflow_sticky", 32'(underflow), 32'd1);

    // drop en mid-frame: frame completes, then idle
    advance_to(6, 2);
    n = 0;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick(1'b0, 1'b1);
      n++;
      if (!busy) done = 1'b1;
    end
    check("drain_len", 32'(n), 32'd27);
    fs_n = 0; busy_n = 0;
    for (int i = 0; i < 20; i++) begin
      tick(1'b0, 1'b1);
      if (frame_start) fs_n++;
      if (busy) busy_n++;
    end
    check("idle_frame_start", 32'(fs_n), 32'd0);
    check("idle_busy", 32'(busy_n), 32'd0);
    check("idle_underflow", 32'(underflow), 32'd0);

    // restart, brief en drop then re-assert: no gap in frame cadence
    fs_a = -1; fs_b = -1; busy_n = 0; drop_left = 0; drop_done = 1'b0;
    for (int i = 0; i < 130; i++) begin
      e = 1'b1;
      if (fs_a >= 0 && !drop_done && m_v == 2 && m_h == 6) begin
        drop_left = 10;
        drop_done = 1'b1;
      end
      if (drop_left > 0) begin
        e = 1'b0;
        drop_left--;
      end
      pv = !(m_v == 3 && m_h == 5);
      tick(e, pv);
      if (!busy) busy_n++;
      if (frame_start) begin
        if (fs_a < 0) fs_a = i;
        else if (fs_b < 0) fs_b = i;
      end
    end
    check("restart_fs_first", 32'(fs_a), 32'd1);
    check("reassert_fs_period", 32'(fs_b - fs_a), 32'd55);
    check("reassert_busy_gap", 32'(busy_n), 32'd0);

    // reset mid-line inside an active slot
    advance_to(7, 3);
    check("pre_reset_underflow", 32'(underflow), 32'd1);
    step(1'b0, 1'b1, 1'b1, dctr);
    check("rst_vde", 32'(vde), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_cd0", 32'(cd0), 32'd3);
    tick(1'b1, 1'b1);
    check("rel_fs_1", 32'(frame_start), 32'd0);
    tick(1'b1, 1'b1);
    check("rel_fs_2", 32'(frame_start), 32'd1);
    check("rel_cd0", 32'(cd0), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
